ifu_fetch_ctrl: RTL
===================

Name: ifu_fetch_ctrl

Overview:
- Fetch master placed directly upstream of the instruction-memory read slave.
- Holds the PC and issues one AXI-lite read per instruction on the AR/R channels.
- Captures the returned word and presents it to decode with a valid/ready handshake.
- Accepts the next PC from the execute/writeback path before starting the next fetch. One transaction is outstanding at most.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- CNT_W, 32, width of the completed-fetch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- araddr  out  32  read address; always equals the PC register.
- arvalid  out  1  read-address valid.
- arready  in  1  read-address ready from the memory slave.
- rdata  in  32  read data.
- rresp  in  1  read response; 1 = bus error.
- rvalid  in  1  read-data valid.
- rready  out  1  read-data ready.
- inst  out  32  fetched instruction.
- inst_pc  out  32  PC of `inst`.
- inst_err  out  2  status: 00 ok, 01 bus error, 10 misaligned PC.
- inst_valid  out  1  instruction valid to decode.
- inst_ready  in  1  decode accepts.
- npc  in  32  next PC.
- npc_valid  in  1  next PC valid.
- npc_ready  out  1  controller accepts the next PC.
- fetch_cnt  out  CNT_W  number of instructions accepted by decode.

Behaviour:
- States: REQ, RESP, OUT, WAIT_PC. All outputs are registered or decoded from state only; there is no combinational in-to-out path.
- Reset (rst=1 at a clk edge):
  - state=REQ, pc=RESET_PC, inst=0, inst_pc=0, inst_err=0, fetch_cnt=0.
  - During the reset cycle arvalid, rready, inst_valid and npc_ready are 0. arvalid first goes high in the first cycle after rst is low.
  - Reset mid-transaction abandons it. The slave is reset by the same rst, so no stale response is expected.
- REQ:
  - arvalid=1, araddr=pc.
  - arvalid stays high and araddr stays stable until arvalid&&arready.
  - arready seen high before arvalid is ignored. The controller must not wait for arready before raising arvalid.
  - On handshake go to RESP the next cycle.
- RESP:
  - rready=1, arvalid=0.
  - On rvalid&&rready: inst<=rdata, inst_pc<=pc, inst_err<={1'b0,rresp}, go to OUT.
  - rvalid arriving any number of cycles later is legal. There is no timeout.
- OUT:
  - inst_valid=1. inst, inst_pc and inst_err are held stable until inst_ready.
  - On inst_valid&&inst_ready: fetch_cnt<=fetch_cnt+1 (wraps at 2^CNT_W), go to WAIT_PC.
  - inst_ready asserted early (before OUT) has no effect.
- WAIT_PC:
  - npc_ready=1.
  - On npc_valid: pc<=npc.
  - If npc[1:0]==0, go to REQ.
  - Otherwise skip the bus and go straight to OUT with inst=0, inst_pc=npc, inst_err=2'b10.
  - npc_valid outside WAIT_PC is ignored and not stored.
- Bus error: the instruction is still delivered with inst_err=01. The controller does not halt; decode/WBU decide what to do.
- Latency, per instruction, zero-wait slave: REQ→RESP 1 cycle, RESP→OUT 1 cycle, OUT→WAIT_PC on accept, WAIT_PC→REQ 1 cycle. Minimum 4 cycles per instruction.
- Protocol invariants:
  - arvalid and rready are never high in the same cycle.
  - A second AR is never issued before the R handshake of the first.

Test Plan:
- Reset, then a zero-wait slave returning 32'h0000_0413 at 0x8000_0000 → arvalid high in cycle 1, araddr=0x8000_0000; inst_valid in cycle 3 with inst=0x0000_0413, inst_pc=0x8000_0000, inst_err=00.
- Slave delays arready 10 cycles and rvalid 5 cycles; decode holds inst_ready low for 3 cycles → araddr/arvalid stable throughout the wait, exactly one AR handshake, inst held stable, fetch_cnt increments once.
- Sequential loop: npc=pc+4 for 8 instructions, slave returns the address as data → inst sequence 0x8000_0000…0x8000_001C, fetch_cnt=8, never arvalid&&rready.
- rresp=1 on the read of 0x8000_0010 → inst_err=01, inst=rdata delivered; the next fetch proceeds normally.
- npc=0x8000_0006 → no AR issued; inst_valid next cycle with inst=0, inst_pc=0x8000_0006, inst_err=10.
- rst asserted while in RESP with rvalid pending, then released → pc=0x8000_0000, fetch_cnt=0, inst_valid=0, a new AR to 0x8000_0000 is issued; fetch_cnt wraps from 2^CNT_W−1 to 0 when preloaded via a bench with CNT_W=4.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction fetch master issuing one AXI-lite read per instruction and handing it to decode
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic             rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [1:0]       inst_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic [31:0]      npc,
  input  logic             npc_valid,
  output logic             npc_ready,
  output logic [CNT_W-1:0] fetch_cnt
);
  typedef enum logic [1:0] {REQ, RESP, OUT, WAIT_PC} state_t;
  state_t      state, state_nx;
  logic        run;
  logic [31:0] pc;
  assign araddr = pc;
  // handshake outputs decode from state; run keeps arvalid low through the reset cycle
  always_comb begin
    arvalid    = run && state == REQ;
    rready     = state == RESP;
    inst_valid = state == OUT;
    npc_ready  = state == WAIT_PC;
    state_nx   = state;
    if (arvalid && arready) state_nx = RESP;
    if (rvalid && rready) state_nx = OUT;
    if (inst_valid && inst_ready) state_nx = WAIT_PC;
    if (npc_ready && npc_valid) state_nx = npc[1:0] == 2'b00 ? REQ : OUT;
  end
  // state, pc, captured instruction and completed-fetch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      run       <= 1'b0;
      pc        <= RESET_PC;
      inst      <= '0;
      inst_pc   <= '0;
      inst_err  <= '0;
      fetch_cnt <= '0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
      if (rvalid && rready) begin
        inst     <= rdata;
        inst_pc  <= pc;
        inst_err <= {1'b0, rresp};
      end
      if (inst_valid && inst_ready) fetch_cnt <= fetch_cnt + CNT_W'(1);
      if (npc_ready && npc_valid) begin
        pc <= npc;
        if (npc[1:0] != 2'b00) begin
          inst     <= '0;
          inst_pc  <= npc;
          inst_err <= 2'b10;
        end
      end
    end
  end
endmodule
